imem_boot_controller: RTL and testbench

- Run-control sequencer in front of the pipelined processor.
- Streams a program image, byte by byte, into instruction memory through the processor's byte-wide write port (We / write_address / write_data).
- Releases pc_enable to start execution, then freezes the PC and drains the 5-stage pipeline on halt or cycle limit.
- Guarantees memory writes and instruction fetch never overlap.

---
 rtl/cpu_ctrl_pkg.sv | 16 +
 rtl/byte_load_counter.sv | 38 +++
 rtl/imem_boot_controller.sv | 95 +++++++++
 tb/tb_imem_boot_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: run-control state encoding, pipeline depth and load-length legality
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_READY = 3'd3,
    ST_RUN   = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;
  localparam int unsigned PIPE_DEPTH = 5;
  // images are loaded as whole 32-bit words
  function automatic logic len_legal(input logic [15:0] len, input int unsigned max_bytes);
    return len != 16'd0 && {16'd0, len} <= max_bytes && len[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/byte_load_counter.sv
// byte_load_counter: byte index, registered memory write port and last-byte detect
module byte_load_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] len,
  input  logic        step,
  input  logic [7:0]  data,
  output logic        we,
  output logic [31:0] addr,
  output logic [7:0]  wdata,
  output logic        last
);
  logic [15:0] k;
  logic [15:0] len_q;
  assign last = k == len_q - 16'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k     <= '0;
      len_q <= '0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      we <= step;
      if (clear) begin
        k     <= '0;
        len_q <= len;
      end else if (step) begin
        k     <= k + 16'd1;
        addr  <= BASE_ADDR + {16'd0, k};
        wdata <= data;
      end
    end
  end
endmodule

// File: rtl/imem_boot_controller.sv
// imem_boot_controller: loads a program image into instruction memory, then runs and drains the pipeline
module imem_boot_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned MAX_BYTES    = 1024,
  parameter int unsigned DRAIN_CYCLES = PIPE_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_load,
  input  logic [15:0] load_len,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic [31:0] run_limit,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [7:0]  imem_wdata,
  output logic        pc_enable,
  output logic [2:0]  state,
  output logic        err_len,
  output logic        done,
  output logic [31:0] run_cycles
);
  state_e      st;
  logic [31:0] lim;
  logic [15:0] dcnt;
  logic        last, can_load, load_ok, load_go, hs, lim_hit;
  assign state    = st;
  assign in_ready = st == ST_LOAD;
  assign hs       = in_valid & in_ready;
  assign can_load = st == ST_IDLE || st == ST_READY;
  assign load_ok  = len_legal(load_len, MAX_BYTES);
  assign load_go  = can_load && start_load && load_ok;
  assign lim_hit  = lim != 32'd0 && run_cycles == lim - 32'd1;
  byte_load_counter #(.BASE_ADDR(BASE_ADDR)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(load_go),
    .len  (load_len),
    .step (hs),
    .data (in_data),
    .we   (imem_we),
    .addr (imem_addr),
    .wdata(imem_wdata),
    .last (last)
  );
  // done is registered, so it appears in the first READY cycle after the drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      lim        <= '0;
      dcnt       <= '0;
      pc_enable  <= 1'b0;
      err_len    <= 1'b0;
      done       <= 1'b0;
      run_cycles <= '0;
    end else begin
      err_len <= can_load && start_load && !load_ok;
      done    <= 1'b0;
      case (st)
        ST_IDLE:  if (load_go) st <= ST_LOAD;
        ST_LOAD:  if (hs && last) st <= ST_FLUSH;
        ST_FLUSH: st <= ST_READY;
        ST_READY: begin
          if (load_go) st <= ST_LOAD;
          else if (run_req) begin
            st         <= ST_RUN;
            lim        <= run_limit;
            run_cycles <= '0;
            pc_enable  <= 1'b1;
          end
        end
        ST_RUN: begin
          run_cycles <= run_cycles == '1 ? run_cycles : run_cycles + 32'd1;
          if (halt_req || lim_hit) begin
            st        <= ST_DRAIN;
            dcnt      <= 16'(DRAIN_CYCLES - 1);
            pc_enable <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (dcnt == 16'd0) begin
            st   <= ST_READY;
            done <= 1'b1;
          end else dcnt <= dcnt - 16'd1;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_controller.sv
// tb_imem_boot_controller: scoreboard bench with a spec-level model of loads, runs and drains
module tb_imem_boot_controller;
  localparam int DRAIN = 5;
  logic clk = 0, rst_n = 0, start_load = 0, in_valid = 0, run_req = 0, halt_req = 0;
  logic [15:0] load_len = '0;
  logic [7:0]  in_data = '0;
  logic [31:0] run_limit = '0;
  logic in_ready, imem_we, pc_enable, err_len, done;
  logic [31:0] imem_addr, run_cycles;
  logic [7:0]  imem_wdata;
  logic [2:0]  state;
  int checks = 0, errors = 0;
  logic [39:0] wq[$];
  int rq[$];
  logic [39:0] w;
  int err_cnt = 0, done_cnt = 0, pc_run = 0, gap = 0, exp_n;
  bit live = 0, prev_pc = 0;

  always #5 clk = ~clk;

  imem_boot_controller dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .run_req(run_req),
    .halt_req(halt_req), .run_limit(run_limit), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc_enable(pc_enable), .state(state), .err_len(err_len),
    .done(done), .run_cycles(run_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input int n);
    return n >= 1 && n <= 1024 && n % 4 == 0;
  endfunction

  // monitor: pops expected writes and run results whenever the DUT presents them
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready_decode", in_ready, 32'(state == 3'd1));
      if (imem_we) begin
        chk("we_pc_exclusive", pc_enable, 0);
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", imem_addr, imem_wdata);
        end else begin
          w = wq.pop_front();
          chk("write_addr", imem_addr, w[39:8]);
          chk("write_data", 32'(imem_wdata), 32'(w[7:0]));
        end
      end
      if (err_len) err_cnt++;
      if (done) begin
        done_cnt++;
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: run_cycles %0d, no done expected", run_cycles);
        end else begin
          exp_n = rq.pop_front();
          chk("run_cycles", run_cycles, 32'(exp_n));
          chk("pc_high_cycles", 32'(pc_run), 32'(exp_n));
          chk("drain_gap", 32'(gap), DRAIN);
          chk("state_at_done", 32'(state), 3);
        end
      end
      if (pc_enable) begin
        if (!prev_pc) pc_run = 0;
        pc_run++;
        gap = 0;
      end else gap++;
      prev_pc = pc_enable;
    end
  end

  task automatic do_err(input int n);
    int e0;
    logic [2:0] s0;
    e0 = err_cnt;
    s0 = state;
    @(posedge clk); #1 start_load = 1; load_len = 16'(n);
    @(posedge clk); #1 start_load = 0;
    chk("err_stay_state", 32'(state), 32'(s0));
    repeat (2) @(posedge clk);
    #1 chk("err_pulse_count", 32'(err_cnt - e0), 1);
  endtask

  // mode 0: back-to-back, 1: in_valid alternating, 2: random gaps; abort_at>0 resets after that byte
  task automatic do_load(input int n, input int mode, input int abort_at);
    logic [7:0] b;
    @(posedge clk); #1 start_load = 1; load_len = 16'(n);
    @(posedge clk); #1 start_load = 0;
    chk("load_entered", 32'(state), 1);
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i > 0) begin in_valid = 0; @(posedge clk); #1; end
      if (mode == 2) repeat ($urandom_range(0, 2)) begin in_valid = 0; @(posedge clk); #1; end
      b = mode == 2 ? 8'($urandom) : 8'((i + 1) * 17);
      wq.push_back({32'(i), b});
      in_valid = 1; in_data = b;
      @(posedge clk); #1;
      if (i + 1 == abort_at) begin
        in_valid = 0; rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        chk("rst_state", 32'(state), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_pc_enable", 32'(pc_enable), 0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_writes_seen", 32'(wq.size()), 0);
        return;
      end
    end
    in_valid = 0;
    chk("flush_state", 32'(state), 2);
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_we", 32'(imem_we), 1);
    @(posedge clk); #1;
    chk("ready_state", 32'(state), 3);
    chk("writes_drained", 32'(wq.size()), 0);
  endtask

  // halt_req is asserted during RUN cycle h (0 = never); extra also raises start_load/run_req then
  task automatic do_run(input int lim, input int h, input bit extra);
    int n, d0;
    n = (lim != 0 && (h == 0 || lim < h)) ? lim : h;
    d0 = done_cnt;
    rq.push_back(n);
    @(posedge clk); #1 run_req = 1; run_limit = 32'(lim);
    @(posedge clk); #1 run_req = 0;
    chk("run_pc_on", 32'(pc_enable), 1);
    if (h > 0) begin
      repeat (h - 1) @(posedge clk);
      #1 halt_req = 1;
      if (extra) begin start_load = 1; load_len = 16'd8; run_req = 1; end
      @(posedge clk); #1 halt_req = 0; start_load = 0; run_req = 0;
      if (n == h) begin
        chk("halt_pc_off", 32'(pc_enable), 0);
        chk("halt_state_drain", 32'(state), 5);
      end
    end
    for (int c = 0; c < n + DRAIN + 10 && done_cnt == d0; c++) @(posedge clk);
    #1;
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, d0 + 1);
    end
    chk("post_run_state", 32'(state), 3);
  endtask

  initial begin
    int n, lim;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_we", 32'(imem_we), 0);
    chk("reset_pc", 32'(pc_enable), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_run_cycles", run_cycles, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_err_done", 32'({err_len, done}), 0);
    rst_n = 1; live = 1;
    do_err(6);
    do_err(0);
    do_err(1028);
    do_load(8, 0, 0);
    do_load(8, 1, 0);
    do_run(10, 0, 0);
    do_run(0, 3, 1);
    do_run(4, 4, 0);
    do_load(16, 0, 3);
    do_load(4, 0, 0);
    do_load(1024, 0, 0);
    do_err(1025);
    for (int it = 0; it < 8; it++) begin
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1020, 1030)) : int'($urandom_range(0, 44));
      if (legal(n)) do_load(n, 2, 0);
      else do_err(n);
      for (int r = 0; r < 2; r++) begin
        lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 25));
        do_run(lim, lim == 0 ? int'($urandom_range(1, 20)) : int'($urandom_range(0, lim + 3)), $urandom_range(0, 1) == 1);
      end
    end
    chk("scoreboard_empty", 32'(wq.size() + rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
